arith_fetch: RTL and testbench
==============================

Name: arith_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of mips_decode.
- Holds the PC and issues word fetches to a synchronous-read instruction memory.
- Buffers returned words in a 2-entry FIFO and presents them to the decode stage with a valid/ready handshake, pre-split into fields.
- Halts permanently when the decoder flags an unrecognised instruction (except); only reset clears the halt.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (first fetch address).
- PC_W, 32, PC and memory address width.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PC_W  byte address of the fetch; equals the current PC
- imem_rdata  in  32  instruction word; valid exactly one cycle after a cycle with imem_req=1
- inst_valid  out  1  an instruction is presented to decode
- inst_ready  in  1  decode accepts the instruction this cycle
- inst  out  32  head instruction word
- inst_pc  out  PC_W  PC of the head instruction
- opcode  out  6  inst[31:26]
- rs  out  5  inst[25:21]
- rt  out  5  inst[20:16]
- rd  out  5  inst[15:11]
- funct  out  6  inst[5:0]
- imm16  out  16  inst[15:0]
- except  in  1  decoder exception for the head instruction; meaningful only when inst_valid=1
- halted  out  1  stage is halted

Behaviour:
- States: RUN and HALT.
  - Reset forces RUN, pc=RESET_PC, FIFO empty, inflight=0.
  - RUN to HALT when inst_valid & inst_ready & except.
  - HALT is absorbing until reset.
- Reset values: imem_req=0 during the reset cycle, imem_addr=RESET_PC, inst_valid=0, halted=0. Field outputs are don't-care while inst_valid=0.
- Credit rule: imem_req = RUN & !reset & (count + inflight - pop < 2).
  - count is FIFO occupancy (0..2).
  - inflight is a 1-bit register set to imem_req each cycle.
  - pop = inst_valid & inst_ready.
- On imem_req:
  - pc <= pc + 4, wrapping modulo 2^PC_W (32'hFFFF_FFFC goes to 0).
  - The issued pc is captured alongside inflight as its tag.
- Memory response: when inflight=1, {imem_rdata, tag} is pushed into the FIFO at the end of that cycle.
  - The credit rule guarantees no overflow.
  - A push and a pop in the same cycle are legal in every state and leave count unchanged.
- Latency: a request in cycle t presents inst_valid=1 in cycle t+2; there is no bypass of the FIFO.
- Throughput: with inst_ready held at 1, one instruction is accepted per cycle in steady state.
- Backpressure: while inst_ready=0, inst and inst_pc hold stable. Issue stops once count + inflight reaches 2. No word is lost or duplicated.
- Program order: inst_pc values presented are strictly sequential (+4) in the absence of reset.
- Exception handling:
  - The excepting instruction's pop completes, but the instruction is treated as not executed by downstream stages.
  - Next cycle: FIFO flushed, any in-flight response discarded, inst_valid=0, imem_req=0, halted=1, pc frozen.
- except while inst_ready=0 has no effect.
- Reset mid-operation (any state, any occupancy): the next cycle is identical to the post-reset cycle; pending data is discarded.
- imem_rdata while inflight=0 is ignored.

Decomposition:
- Shared package:
  - Field bit positions and widths (OPCODE_MSB/LSB, RS_, RT_, RD_, FUNCT_, IMM_).
  - Default RESET_PC.
  - Instruction-width constant (32).
- One sub-module: fetch_fifo, a 2-entry FIFO of {pc, word} with push/pop/count and same-cycle push+pop support.
- The PC register, credit logic and RUN/HALT state live in arith_fetch.

Test Plan:
- Reset then inst_ready=1, memory returning words from an array:
  - First req at addr 0x00400000.
  - inst_valid rises 2 cycles later.
  - inst_pc sequence is 0x00400000, 0x00400004, 0x00400008, one per cycle.
- Word 0x012A4020 (add $8,$9,$10) fetched: opcode=0, rs=9, rt=10, rd=8, funct=0x20, imm16=0x4020.
- inst_ready=0 for 5 cycles mid-stream:
  - imem_req drops after count + inflight = 2.
  - inst and inst_pc hold stable.
  - On release, the stream resumes with no gap in inst_pc and no duplicate.
- except=1 with inst_ready=1 at inst_pc 0x0040000C:
  - Next cycle halted=1, inst_valid=0, imem_req=0.
  - halted remains 1 for 10 cycles.
  - The pending response at 0x00400010 is dropped.
- Reset asserted while the FIFO is full and halted=0, and again while halted=1: following cycle gives halted=0, FIFO empty, first request at RESET_PC.
- RESET_PC=32'hFFFF_FFF8 with inst_ready=1: inst_pc sequence is FFFFFFF8, FFFFFFFC, 00000000.

Source files
------------

// File: rtl/arith_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_fetch_pkg
//  Description : Shared constants for the fetch stage: instruction width,
//                default reset PC and MIPS field bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_fetch_pkg;

    localparam int INST_W = 32;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // Field bit positions inside a 32-bit MIPS instruction word
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

endpackage
`default_nettype wire

// File: rtl/arith_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : arith_fetch_fifo
//  Description : Two-entry FIFO holding {word, pc} pairs returned from the
//                instruction memory. Supports push and pop in the same cycle
//                and a synchronous flush that empties it.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic [1:0]       o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    // Entry storage; occupancy decides visibility, so no reset is needed here
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; flush behaves like reset
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_empty     = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/arith_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : arith_fetch
//  Description : Instruction-fetch stage feeding mips_decode. Holds the PC,
//                issues credit-limited fetches to a synchronous-read memory,
//                buffers returned words in a 2-entry FIFO and presents them
//                pre-split into fields. Halts permanently on a decoder
//                exception until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_fetch
    import arith_fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    input  logic              except,
    output logic              halted
);

    localparam logic [0:0]      c_RUN     = 1'b0;
    localparam logic [0:0]      c_HALT    = 1'b1;
    localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(4);
    localparam int              c_ENTRY_W = INST_W + PC_W;

    logic [0:0]           r_state;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      r_tag;
    logic                 r_inflight;

    logic                 w_run;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_halt_now;
    logic                 w_empty;
    logic [1:0]           w_count;
    logic [2:0]           w_occupancy;
    logic [2:0]           w_limit;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_run      = (r_state == c_RUN);
    assign inst_valid = ~w_empty;
    assign w_pop      = inst_valid & inst_ready;
    assign w_halt_now = w_run & w_pop & except;

    // A response arriving after the halt belongs to a discarded fetch
    assign w_push     = r_inflight & w_run;

    // Words already owed to decode (buffered + in flight) must stay below two
    // after this cycle's pop; that keeps the FIFO from ever overflowing.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_limit     = 3'd2 + {2'b00, w_pop};
    assign imem_req    = w_run & ~reset & (w_occupancy < w_limit);
    assign imem_addr   = r_pc;
    assign halted      = (r_state == c_HALT);

    // RUN/HALT state: HALT is absorbing until reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_RUN;
        end else if (w_halt_now) begin
            r_state <= c_HALT;
        end
    end

    // PC advances by one word per issued fetch, wrapping naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (imem_req) begin
            r_pc <= r_pc + c_PC_STEP;
        end
    end

    // In-flight flag marks the cycle the memory returns data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
        end
    end

    // Tag travels with the in-flight fetch so the word is paired with its PC
    always_ff @(posedge clock) begin
        if (imem_req) begin
            r_tag <= r_pc;
        end
    end

    arith_fetch_fifo #(
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_flush     (w_halt_now),
        .i_push      (w_push),
        .i_push_data ({imem_rdata, r_tag}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    assign inst    = w_head[PC_W +: INST_W];
    assign inst_pc = w_head[PC_W-1:0];
    assign opcode  = inst[OPCODE_MSB:OPCODE_LSB];
    assign rs      = inst[RS_MSB:RS_LSB];
    assign rt      = inst[RT_MSB:RT_LSB];
    assign rd      = inst[RD_MSB:RD_LSB];
    assign funct   = inst[FUNCT_MSB:FUNCT_LSB];
    assign imm16   = inst[IMM_MSB:IMM_LSB];

endmodule
`default_nettype wire

// File: tb/tb_arith_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_fetch
//  Description : Self-checking bench for arith_fetch. A queue of issued
//                fetches (address + issue cycle) predicts every output;
//                a second instance checks PC wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_fetch;

    localparam logic [31:0] RESET_PC_A = 32'h0040_0000;
    localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        except;
    logic        halted;

    logic        b_req;
    logic [31:0] b_addr;
    logic [31:0] b_rdata;
    logic        b_valid;
    logic        b_ready = 1'b1;
    logic [31:0] b_inst;
    logic [31:0] b_pc;
    logic [5:0]  b_opcode;
    logic [4:0]  b_rs;
    logic [4:0]  b_rt;
    logic [4:0]  b_rd;
    logic [5:0]  b_funct;
    logic [15:0] b_imm16;
    logic        b_except = 1'b0;
    logic        b_halted;

    always #5 clock = ~clock;

    arith_fetch u_dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .funct(funct), .imm16(imm16), .except(except), .halted(halted)
    );

    arith_fetch #(.RESET_PC(RESET_PC_B)) u_dut_b (
        .clock(clock), .reset(reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_rdata(b_rdata), .inst_valid(b_valid), .inst_ready(b_ready),
        .inst(b_inst), .inst_pc(b_pc), .opcode(b_opcode), .rs(b_rs), .rt(b_rt), .rd(b_rd),
        .funct(b_funct), .imm16(b_imm16), .except(b_except), .halted(b_halted)
    );

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } fetch_t;

    fetch_t      q[$];
    logic [31:0] m_next_pc;
    bit          m_halted;
    int          cyc;
    int          b_n;
    int          checks;
    int          errors;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_req_b;
    logic [31:0] s_addr_b;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0008) return 32'h012A_4020;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        bit          ev;
        bit          pop;
        bit          er;
        logic [31:0] w;
        logic [31:0] eb;
        if (reset) begin
            chk("req_in_reset", imem_req, 1'b0);
            q.delete();
            m_next_pc = RESET_PC_A;
            m_halted  = 1'b0;
            b_n       = 0;
        end else begin
            ev = !m_halted && (q.size() > 0) && (cyc - q[0].cyc >= 2);
            chk("inst_valid", inst_valid, ev);
            chk("halted", halted, m_halted);
            chk("imem_addr", imem_addr, m_next_pc);
            if (ev) begin
                w = mem_word(q[0].pc);
                chk("inst_pc", inst_pc, q[0].pc);
                chk("inst", inst, w);
                chk("opcode", opcode, w[31:26]);
                chk("rs", rs, w[25:21]);
                chk("rt", rt, w[20:16]);
                chk("rd", rd, w[15:11]);
                chk("funct", funct, w[5:0]);
                chk("imm16", imm16, w[15:0]);
                if (q[0].pc == 32'h0040_0008) begin
                    chk("add_opcode", opcode, 6'd0);
                    chk("add_rs", rs, 5'd9);
                    chk("add_rt", rt, 5'd10);
                    chk("add_rd", rd, 5'd8);
                    chk("add_funct", funct, 6'h20);
                    chk("add_imm16", imm16, 16'h4020);
                end
            end
            pop = ev && inst_ready;
            er  = !m_halted && ((q.size() - int'(pop)) < 2);
            chk("imem_req", imem_req, er);
            if (pop) void'(q.pop_front());
            if (er) begin
                q.push_back('{pc: m_next_pc, cyc: cyc});
                m_next_pc = m_next_pc + 32'd4;
            end
            if (pop && except) begin
                m_halted = 1'b1;
                q.delete();
            end
            if (b_valid && b_n < 3) begin
                eb = RESET_PC_B + 32'(4 * b_n);
                chk("wrap_inst_pc", b_pc, eb);
                chk("wrap_inst", b_inst, mem_word(eb));
                b_n++;
            end
        end
        cyc++;
    endtask

    task automatic cycle(input bit rst, input bit rdy, input bit exc);
        reset      = rst;
        inst_ready = rdy;
        except     = exc;
        @(negedge clock);
        observe();
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_req_b  = b_req;
        s_addr_b = b_addr;
        @(posedge clock);
        #1;
        imem_rdata = s_req   ? mem_word(s_addr)   : $urandom();
        b_rdata    = s_req_b ? mem_word(s_addr_b) : $urandom();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        b_n        = 0;
        m_next_pc  = RESET_PC_A;
        m_halted   = 1'b0;
        reset      = 1'b1;
        inst_ready = 1'b0;
        except     = 1'b0;
        imem_rdata = 32'd0;
        b_rdata    = 32'd0;
        @(posedge clock);
        #1;

        // Streaming from reset, then 5-cycle backpressure, then release
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        repeat (6) cycle(0, 1, 0);
        repeat (5) cycle(0, 0, 0);
        repeat (6) cycle(0, 1, 0);

        // Exception on the instruction at 0x0040000C (sixth cycle after reset)
        cycle(1, 1, 0);
        repeat (5) cycle(0, 1, 0);
        cycle(0, 1, 1);
        repeat (10) cycle(0, 1, 0);

        // Reset while halted, then fill the FIFO and reset while full
        cycle(1, 1, 0);
        repeat (6) cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (6) cycle(0, 1, 0);

        // Randomized traffic with sporadic exceptions and resets
        repeat (800) begin
            cycle($urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
